decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder feeding a two-entry (output + skid) buffer.
// Define DECODE_MULDIV_EN to decode the M extension (OP with funct7=0000001).
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_ra1,
  output logic [4:0]       out_ra2,
  output logic [4:0]       out_wa3,
  output logic [2:0]       out_funct3,
  output logic             out_src1_sel,
  output logic             out_src2_sel,
  output logic             out_wd3_sel,
  output logic             out_we3,
  output logic             out_wem,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_muldiv,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [4:0]      wa3;
    logic [2:0]      funct3;
    logic            src1_sel;
    logic            src2_sel;
    logic            wd3_sel;
    logic            we3;
    logic            wem;
    logic            branch;
    logic            jump;
    logic            muldiv;
    logic            illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        illegal;
  entry_t      dec;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];
  assign funct3 = in_instr[14:12];

  always_comb begin
    dec     = '0;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm32        = {in_instr[31:12], 12'b0};
        dec.src2_sel = 1'b1;
        dec.we3      = 1'b1;
      end
      OPC_AUIPC: begin
        imm32        = {in_instr[31:12], 12'b0};
        dec.src1_sel = 1'b1;
        dec.src2_sel = 1'b1;
        dec.we3      = 1'b1;
      end
      OPC_JAL: begin
        imm32        = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
        dec.src1_sel = 1'b1;
        dec.we3      = 1'b1;
        dec.jump     = 1'b1;
      end
      OPC_JALR: begin
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src1_sel = 1'b1;
        dec.we3      = 1'b1;
        dec.jump     = 1'b1;
        dec.ra1      = in_instr[19:15];
      end
      OPC_BRANCH: begin
        imm32        = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
        dec.branch   = 1'b1;
        dec.ra1      = in_instr[19:15];
        dec.ra2      = in_instr[24:20];
      end
      OPC_LOAD: begin
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_sel = 1'b1;
        dec.wd3_sel  = 1'b1;
        dec.we3      = 1'b1;
        dec.ra1      = in_instr[19:15];
      end
      OPC_STORE: begin
        imm32        = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.src2_sel = 1'b1;
        dec.wem      = 1'b1;
        dec.ra1      = in_instr[19:15];
        dec.ra2      = in_instr[24:20];
      end
      OPC_OPIMM: begin
        imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_sel = 1'b1;
        dec.we3      = 1'b1;
        dec.ra1      = in_instr[19:15];
        // Shifts: only bit 30 (SRAI) may be set above the 5-bit shamt.
        if (funct3 == 3'b001 && funct7 != 7'b0)
          illegal = 1'b1;
        if (funct3 == 3'b101 && {funct7[6], funct7[4:0]} != 6'b0)
          illegal = 1'b1;
      end
      OPC_OP: begin
        dec.we3 = 1'b1;
        dec.ra1 = in_instr[19:15];
        dec.ra2 = in_instr[24:20];
        if (funct7 == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
          dec.muldiv = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11)
      illegal = 1'b1;

    dec.pc     = in_pc;
    dec.funct3 = funct3;
    dec.imm    = XLEN'($signed(imm32));
    if (dec.we3)
      dec.wa3 = in_instr[11:7];
    if (illegal) begin
      dec.imm      = '0;
      dec.ra1      = '0;
      dec.ra2      = '0;
      dec.wa3      = '0;
      dec.src1_sel = 1'b0;
      dec.src2_sel = 1'b0;
      dec.wd3_sel  = 1'b0;
      dec.we3      = 1'b0;
      dec.wem      = 1'b0;
      dec.branch   = 1'b0;
      dec.jump     = 1'b0;
      dec.muldiv   = 1'b0;
    end
    dec.illegal = illegal;
  end

  entry_t            out_entry_reg, out_entry_next;
  entry_t            skid_entry_reg, skid_entry_next;
  logic              out_valid_reg, out_valid_next;
  logic              skid_valid_reg, skid_valid_next;
  logic              in_ready_reg, in_ready_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    out_entry_next  = out_entry_reg;
    skid_entry_next = skid_entry_reg;
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    cnt_next        = cnt_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      if (!out_valid_reg || out_ready) begin
        // Output slot frees up: oldest entry (skid first) moves in.
        if (skid_valid_reg) begin
          out_valid_next  = 1'b1;
          out_entry_next  = skid_entry_reg;
          skid_valid_next = in_fire;
          if (in_fire)
            skid_entry_next = dec;
        end else begin
          out_valid_next = in_fire;
          if (in_fire)
            out_entry_next = dec;
        end
      end else if (in_fire) begin
        skid_valid_next = 1'b1;
        skid_entry_next = dec;
      end
      if (out_fire && out_entry_reg.illegal && cnt_reg != '1)
        cnt_next = cnt_reg + CNT_W'(1);
    end
    in_ready_next = ~skid_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_entry_reg  <= '0;
      skid_entry_reg <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      out_entry_reg  <= out_entry_next;
      skid_entry_reg <= skid_entry_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= in_ready_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign out_pc       = out_entry_reg.pc;
  assign out_imm      = out_entry_reg.imm;
  assign out_ra1      = out_entry_reg.ra1;
  assign out_ra2      = out_entry_reg.ra2;
  assign out_wa3      = out_entry_reg.wa3;
  assign out_funct3   = out_entry_reg.funct3;
  assign out_src1_sel = out_entry_reg.src1_sel;
  assign out_src2_sel = out_entry_reg.src2_sel;
  assign out_wd3_sel  = out_entry_reg.wd3_sel;
  assign out_we3      = out_entry_reg.we3;
  assign out_wem      = out_entry_reg.wem;
  assign out_branch   = out_entry_reg.branch;
  assign out_jump     = out_entry_reg.jump;
  assign out_muldiv   = out_entry_reg.muldiv;
  assign out_illegal  = out_entry_reg.illegal;
  assign illegal_cnt  = cnt_reg;

endmodule
